// File: rtl/cla_pipe_adder_if.sv
// Operand/result handshake bundle for the pipelined CLA adder.
// The master drives operands and out_ready; the slave (the adder) returns results.
interface cla_pipe_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );
endinterface

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// Stage 1 registers bit and group propagate/generate; stage 2 resolves carries and flags.
module cla_pipe_adder #(
    parameter int WIDTH = 16,
    parameter int BLK   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    cla_pipe_adder_if.slave   bus
);
    localparam int NG = WIDTH / BLK;

    logic [WIDTH-1:0] bb_s;
    logic             c0_s;
    logic [WIDTH-1:0] p_s;
    logic [WIDTH-1:0] g_s;
    logic [NG-1:0]    gp_s;
    logic [NG-1:0]    gg_s;

    logic [WIDTH-1:0] p_r;
    logic [WIDTH-1:0] g_r;
    logic [NG-1:0]    gp_r;
    logic [NG-1:0]    gg_r;
    logic             c0_r;
    logic             amsb_r;
    logic             bmsb_r;
    logic             v1_r;

    logic [NG:0]      gc_s;
    logic [WIDTH:0]   c_s;
    logic [WIDTH-1:0] sum_s;

    logic             adv2_s;
    logic             in_ready_s;
    logic             take_s;

    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             ovf_r;
    logic             zero_r;
    logic             out_valid_r;

    // Subtraction is a + ~b + 1, so condition B and the carry-in up front.
    always_comb begin
        bb_s = bus.sub ? ~bus.b : bus.b;
        c0_s = bus.sub ? 1'b1 : bus.cin;
    end

    assign p_s = bus.a ^ bb_s;
    assign g_s = bus.a & bb_s;

    // Group propagate/generate as flat sum-of-products over each BLK-bit group.
    always_comb begin : grp_pg_c
        logic acc;
        acc  = 1'b0;
        gp_s = '0;
        gg_s = '0;
        for (int k = 0; k < NG; k++) begin
            gp_s[k] = &p_s[k*BLK +: BLK];
            for (int i = 0; i < BLK; i++) begin
                acc = g_s[k*BLK+i];
                for (int m = i + 1; m < BLK; m++) begin
                    acc = acc & p_s[k*BLK+m];
                end
                gg_s[k] = gg_s[k] | acc;
            end
        end
    end

    assign adv2_s     = ~out_valid_r | bus.out_ready;
    assign in_ready_s = ~v1_r | adv2_s;
    assign take_s     = bus.in_valid & in_ready_s;

    // Stage 1 register: captures conditioned operands on an input transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_r   <= 1'b0;
            p_r    <= '0;
            g_r    <= '0;
            gp_r   <= '0;
            gg_r   <= '0;
            c0_r   <= 1'b0;
            amsb_r <= 1'b0;
            bmsb_r <= 1'b0;
        end else begin
            if (in_ready_s) begin
                v1_r <= bus.in_valid;
            end
            if (take_s) begin
                p_r    <= p_s;
                g_r    <= g_s;
                gp_r   <= gp_s;
                gg_r   <= gg_s;
                c0_r   <= c0_s;
                amsb_r <= bus.a[WIDTH-1];
                bmsb_r <= bb_s[WIDTH-1];
            end
        end
    end

    // Second-level lookahead: each group carry is a flat function of G, P and c0.
    always_comb begin : grp_carry_c
        logic acc;
        logic any;
        acc     = 1'b0;
        any     = 1'b0;
        gc_s    = '0;
        gc_s[0] = c0_r;
        for (int k = 0; k < NG; k++) begin
            acc = c0_r;
            for (int j = 0; j <= k; j++) begin
                acc = acc & gp_r[j];
            end
            any = acc;
            for (int j = 0; j <= k; j++) begin
                acc = gg_r[j];
                for (int m = j + 1; m <= k; m++) begin
                    acc = acc & gp_r[m];
                end
                any = any | acc;
            end
            gc_s[k+1] = any;
        end
    end

    // Intra-group carries looked ahead from each group's incoming carry.
    always_comb begin : bit_carry_c
        logic acc;
        logic any;
        acc = 1'b0;
        any = 1'b0;
        c_s = '0;
        for (int k = 0; k < NG; k++) begin
            for (int i = 0; i < BLK; i++) begin
                acc = gc_s[k];
                for (int m = 0; m < i; m++) begin
                    acc = acc & p_r[k*BLK+m];
                end
                any = acc;
                for (int j = 0; j < i; j++) begin
                    acc = g_r[k*BLK+j];
                    for (int m = j + 1; m < i; m++) begin
                        acc = acc & p_r[k*BLK+m];
                    end
                    any = any | acc;
                end
                c_s[k*BLK+i] = any;
            end
        end
        c_s[WIDTH] = gc_s[NG];
        sum_s      = p_r ^ c_s[WIDTH-1:0];
    end

    // Stage 2 register: results hold while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            sum_r       <= '0;
            cout_r      <= 1'b0;
            ovf_r       <= 1'b0;
            zero_r      <= 1'b0;
        end else begin
            if (adv2_s) begin
                out_valid_r <= v1_r;
                if (v1_r) begin
                    sum_r  <= sum_s;
                    cout_r <= c_s[WIDTH];
                    // Same as c[W-1]^c[W]: like-signed inputs giving an opposite-signed sum.
                    ovf_r  <= ~(amsb_r ^ bmsb_r) & (amsb_r ^ sum_s[WIDTH-1]);
                    zero_r <= (sum_s == '0);
                end
            end
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.sum       = sum_r;
    assign bus.cout      = cout_r;
    assign bus.ovf       = ovf_r;
    assign bus.zero      = zero_r;
endmodule
